commit_trace_buffer: RTL

Parametrised retirement-trace capture block for the RV32IM datapath. It records one entry per committed instruction: PC, instruction word, destination register and write-back data. Entries go into an on-chip circular buffer, and capture can stop automatically at a programmed stop PC. It sits beside `Datapath`, is fed from its commit-side signals, and gives benches and debug logic a first-word-fall-through drain port. This replaces per-cycle hierarchical peeking at the PC and register file.

---
 rtl/commit_trace_buffer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/commit_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : commit_trace_buffer
//  Brief    : Retirement-trace capture. A circular buffer holds one entry per
//             committed instruction (PC, instruction word, rd, write-back
//             data). Capture can stop automatically at a programmed stop PC.
//             The drain port is first-word-fall-through.
//  Revision : 1.0 - initial release
// ============================================================================
module commit_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int WRAP  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     commit_valid,
    input  logic [XLEN-1:0]          commit_pc,
    input  logic [31:0]              commit_ins,
    input  logic                     commit_regwen,
    input  logic [4:0]               commit_rd,
    input  logic [XLEN-1:0]          commit_wdata,
    input  logic                     stop_en,
    input  logic [XLEN-1:0]          stop_pc,
    input  logic                     arm,
    input  logic                     clear,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [XLEN-1:0]          out_pc,
    output logic [31:0]              out_ins,
    output logic                     out_regwen,
    output logic [4:0]               out_rd,
    output logic [XLEN-1:0]          out_wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     halted,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
);

    localparam int                c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_FULL    = (c_AW + 1)'(DEPTH);
    localparam bit                c_WRAP    = (WRAP != 0);

    localparam logic [0:0]        c_CAPTURE = 1'b0;
    localparam logic [0:0]        c_STOPPED = 1'b1;

    // Entry storage; contents are never reset, only pointers and status are.
    logic [XLEN-1:0]   r_pc_mem    [DEPTH];
    logic [31:0]       r_ins_mem   [DEPTH];
    logic              r_regwen_mem[DEPTH];
    logic [4:0]        r_rd_mem    [DEPTH];
    logic [XLEN-1:0]   r_wdata_mem [DEPTH];

    logic [c_AW-1:0]   r_wptr;
    logic [c_AW-1:0]   r_rptr;
    logic [c_AW:0]     r_count;
    logic              r_overflow;
    logic [15:0]       r_drop_cnt;
    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_wr;
    logic              w_overwrite;
    logic              w_drop;
    logic              w_trig;

    // Transaction qualification. A pop on a full buffer frees the slot the
    // push lands in, so push+pop on full is a plain write with no overwrite.
    always_comb begin
        w_push      = (r_state == c_CAPTURE) && commit_valid;
        w_pop       = (r_count != '0) && out_ready;
        w_full      = (r_count == c_FULL);
        w_wr        = w_push && (!w_full || w_pop || c_WRAP);
        w_overwrite = w_push && w_full && !w_pop && c_WRAP;
        w_drop      = w_push && w_full && !w_pop && !c_WRAP;
        w_trig      = w_push && stop_en && (commit_pc == stop_pc);
    end

    // Entry write port.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_pc_mem[r_wptr]     <= commit_pc;
            r_ins_mem[r_wptr]    <= commit_ins;
            r_regwen_mem[r_wptr] <= commit_regwen;
            r_rd_mem[r_wptr]     <= commit_rd;
            r_wdata_mem[r_wptr]  <= commit_wdata;
        end
    end

    // Pointers, occupancy and sticky status; clear takes priority over traffic.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop || w_overwrite) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_wr && !w_pop && !w_overwrite) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_wr) begin
                r_count <= r_count - 1'b1;
            end
            if (w_overwrite) begin
                r_overflow <= 1'b1;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    // Capture-state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_CAPTURE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: stop on the trigger commit, resume on arm, clear forces capture.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_CAPTURE: if (w_trig) w_state_nxt = c_STOPPED;
            c_STOPPED: if (arm)    w_state_nxt = c_CAPTURE;
            default:               w_state_nxt = c_CAPTURE;
        endcase
        if (clear) begin
            w_state_nxt = c_CAPTURE;
        end
    end

    // Head-of-buffer outputs and status.
    always_comb begin
        out_valid  = (r_count != '0);
        out_pc     = r_pc_mem[r_rptr];
        out_ins    = r_ins_mem[r_rptr];
        out_regwen = r_regwen_mem[r_rptr];
        out_rd     = r_rd_mem[r_rptr];
        out_wdata  = r_wdata_mem[r_rptr];
        count      = r_count;
        halted     = (r_state == c_STOPPED);
        overflow   = r_overflow;
        drop_cnt   = r_drop_cnt;
    end

endmodule
`default_nettype wire
